// File: rtl/phy_tx_par.sv
// Multi-lane parallel-to-serial PHY transmitter: comma alignment burst after reset,
// then per-lane data/idle symbols shifted out MSB first on a shared bit-rate clock.
module phy_tx_par #(
    parameter int unsigned     LANES    = 2,
    parameter int unsigned     WIDTH    = 8,
    parameter logic [WIDTH-1:0] COM     = 8'hBC,
    parameter logic [WIDTH-1:0] IDL     = 8'h7C,
    parameter int unsigned     SYNC_COM = 4
) (
    input  logic                   clk_8f,
    input  logic                   reset_L,
    input  logic                   enable,
    input  logic [LANES*WIDTH-1:0] data_in,
    input  logic [LANES-1:0]       valid_in,
    output logic [LANES-1:0]       ready_out,
    output logic [LANES-1:0]       serial_out,
    output logic                   active_out,
    output logic                   word_strobe
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {RST, SYNC, ACTIVE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       sync_cnt, sync_nxt;
    logic [CW-1:0]    bit_cnt;
    logic             last_slot;
    logic             load;
    logic [WIDTH-1:0] sreg [LANES];
    logic [WIDTH-1:0] sym  [LANES];

    // last_slot is a flop mirroring bit_cnt == WIDTH-1; gating with enable keeps
    // strobes low while frozen without decoding the counter combinationally.
    assign load        = enable & reset_L & last_slot;
    assign word_strobe = load;

    always_comb begin
        state_nxt = state;
        sync_nxt  = sync_cnt;
        case (state)
            RST:    if (enable) state_nxt = SYNC;
            SYNC: begin
                if (load) begin
                    sync_nxt = sync_cnt + 4'd1;
                    if (sync_cnt == 4'(SYNC_COM - 1)) state_nxt = ACTIVE;
                end
            end
            ACTIVE: state_nxt = ACTIVE;
            default: state_nxt = RST;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            sym[i]        = COM;
            ready_out[i]  = 1'b0;
            serial_out[i] = sreg[i][WIDTH-1];
            if (state == ACTIVE) begin
                sym[i]       = valid_in[i] ? data_in[i*WIDTH +: WIDTH] : IDL;
                ready_out[i] = load;
            end
        end
    end

    always_ff @(posedge clk_8f) begin
        if (!reset_L) begin
            state    <= RST;
            sync_cnt <= '0;
        end else if (enable) begin
            state    <= state_nxt;
            sync_cnt <= sync_nxt;
        end
    end

    always_ff @(posedge clk_8f) begin
        if (!reset_L) begin
            bit_cnt    <= '0;
            last_slot  <= 1'b0;
            active_out <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) sreg[i] <= '0;
        end else if (enable) begin
            bit_cnt   <= last_slot ? '0 : bit_cnt + 1'b1;
            last_slot <= (bit_cnt == CW'(WIDTH - 2));
            if (load && state == ACTIVE) active_out <= 1'b1;
            for (int unsigned i = 0; i < LANES; i++) begin
                if (load) sreg[i] <= sym[i];
                else      sreg[i] <= {sreg[i][WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_phy_tx_par.sv
// Randomized scoreboard bench for phy_tx_par: a queue-based bit-stream model predicts
// every output per cycle; a negedge monitor pops and compares.
module tb_phy_tx_par;

    localparam int L  = 2;
    localparam int W  = 8;
    localparam int SC = 4;
    localparam logic [W-1:0] COMV = 8'hBC;
    localparam logic [W-1:0] IDLV = 8'h7C;

    logic           clk_8f = 1'b0;
    logic           reset_L, enable;
    logic [L*W-1:0] data_in;
    logic [L-1:0]   valid_in, ready_out, serial_out;
    logic           active_out, word_strobe;

    phy_tx_par #(
        .LANES(L), .WIDTH(W), .COM(COMV), .IDL(IDLV), .SYNC_COM(SC)
    ) dut (
        .clk_8f(clk_8f), .reset_L(reset_L), .enable(enable),
        .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
        .serial_out(serial_out), .active_out(active_out), .word_strobe(word_strobe)
    );

    always #5 clk_8f = ~clk_8f;

    typedef struct {
        logic [L-1:0] ser;
        logic [L-1:0] rdy;
        logic         ws;
        logic         act;
    } exp_t;

    exp_t         exp_q[$];
    logic [L-1:0] colq[$];
    int           phase, loads;
    bit           act_m;
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        phase = 0;
        loads = 0;
        act_m = 0;
        colq.delete();
        for (int j = 0; j < W; j++) colq.push_back('0);
    endtask

    // One cycle: drive inputs, predict outputs, let the edge happen, advance the model.
    task automatic drive(input logic r, input logic e, input logic [L-1:0] v,
                         input logic [L*W-1:0] d);
        exp_t         rec;
        logic         ld;
        logic [W-1:0] s;
        logic [L-1:0] col;
        reset_L  = r;
        enable   = e;
        valid_in = v;
        data_in  = d;
        ld       = r && e && (phase == W - 1);
        rec.ser  = (colq.size() > 0) ? colq[0] : '0;
        rec.rdy  = (ld && loads >= SC) ? '1 : '0;
        rec.ws   = ld;
        rec.act  = act_m;
        exp_q.push_back(rec);
        @(posedge clk_8f);
        if (!r) begin
            model_reset();
        end else if (e) begin
            if (ld) begin
                for (int j = 0; j < W; j++) begin
                    for (int i = 0; i < L; i++) begin
                        s = (loads < SC) ? COMV : (v[i] ? d[i*W +: W] : IDLV);
                        col[i] = s[W-1-j];
                    end
                    colq.push_back(col);
                end
                if (loads >= SC) act_m = 1;
                else             loads++;
            end
            void'(colq.pop_front());
            phase = (phase + 1) % W;
        end
        #1;
    endtask

    function automatic logic [L*W-1:0] rnd_data();
        logic [L*W-1:0] d;
        int unsigned    r;
        for (int i = 0; i < L; i++) begin
            r = $urandom_range(0, 3);
            d[i*W +: W] = (r == 0) ? COMV : (r == 1) ? IDLV : W'($urandom);
        end
        return d;
    endfunction

    always @(negedge clk_8f) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("serial_out", 16'(serial_out), 16'(e.ser));
            check("ready_out", 16'(ready_out), 16'(e.rdy));
            check("word_strobe", 16'(word_strobe), 16'(e.ws));
            check("active_out", 16'(active_out), 16'(e.act));
        end
    end

    initial begin
        reset_L  = 1'b0;
        enable   = 1'b0;
        valid_in = '0;
        data_in  = '0;
        @(posedge clk_8f);
        model_reset();
        #1;

        // reset dominates enable
        repeat (2) drive(1'b0, 1'b1, '1, rnd_data());

        // alignment burst with valid asserted: must be ignored
        repeat (45) drive(1'b1, 1'b1, L'($urandom), rnd_data());

        // A5 on lane0, lane1 idle, then stall 5 cycles after 3 bits
        while (phase != W - 1) drive(1'b1, 1'b1, '0, rnd_data());
        drive(1'b1, 1'b1, 2'b01, {8'h33, 8'hA5});
        repeat (3) drive(1'b1, 1'b1, L'($urandom), rnd_data());
        repeat (5) drive(1'b1, 1'b0, '1, rnd_data());
        repeat (20) drive(1'b1, 1'b1, L'($urandom), rnd_data());

        // back-to-back extremes on every lane
        while (phase != W - 1) drive(1'b1, 1'b1, '0, rnd_data());
        drive(1'b1, 1'b1, '1, {L{8'hFF}});
        repeat (W - 1) drive(1'b1, 1'b1, '0, rnd_data());
        drive(1'b1, 1'b1, '1, {L{8'h01}});
        repeat (W + 2) drive(1'b1, 1'b1, '0, rnd_data());

        repeat (300) drive(1'b1, ($urandom_range(0, 9) != 0), L'($urandom), rnd_data());

        // reset in the middle of the second comma
        drive(1'b0, 1'b1, '0, rnd_data());
        while (!(loads == 2 && phase == 3)) drive(1'b1, 1'b1, L'($urandom), rnd_data());
        drive(1'b0, 1'b1, '1, rnd_data());
        repeat (60) drive(1'b1, 1'b1, L'($urandom), rnd_data());

        repeat (500) drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0),
                           L'($urandom), rnd_data());

        @(negedge clk_8f);
        #1;
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
